// File: rtl/imem_loader_if.sv
// Byte-stream load port and instruction-memory write bus of imem_loader.
// master drives the stream (load_start/in_valid/in_data); slave is the loader.
interface imem_loader_if #(
  parameter int LEN = 32
);
  logic           load_start;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           mem_we;
  logic [LEN-1:0] mem_addr;
  logic [LEN-1:0] mem_wdata;
  logic           core_reset;
  logic           busy;
  logic           done;
  logic           error;

  modport master (
    output load_start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, core_reset, busy, done, error
  );

  modport slave (
    input  load_start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, core_reset, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: 16-bit word count + little-endian bytes -> imem writes from 0; write one cycle after 4th byte,
// one byte/cycle with in_ready held through writes. Optional trailing XOR byte with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int LEN    = 32,
  parameter int ADDR_W = 10
) (
  input logic          clock,
  input logic          reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  // State reached after the last data byte (or an empty image).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_t         state_q,     state_d;
  logic [7:0]     cnt_lo_q,    cnt_lo_d;
  logic [15:0]    nwords_q,    nwords_d;
  logic [15:0]    wdone_q,     wdone_d;
  logic [1:0]     byte_q,      byte_d;
  logic [23:0]    asm_q,       asm_d;
  logic           mem_we_q,    mem_we_d;
  logic [LEN-1:0] mem_addr_q,  mem_addr_d;
  logic [LEN-1:0] mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]     csum_q,      csum_d;
`endif

  logic in_ready;
  logic accept;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                 in_ready = 1'b1;
`endif
      default:                in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    nwords_d    = nwords_q;
    wdone_d     = wdone_q;
    byte_d      = byte_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_we_q ? mem_addr_q + LEN'(4) : mem_addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.load_start) begin
          state_d    = S_HDR0;
          mem_addr_d = '0;
          byte_d     = 2'd0;
          wdone_d    = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end

      S_HDR0: begin
        if (accept) begin
          cnt_lo_d = bus.in_data;
          state_d  = S_HDR1;
        end
      end

      S_HDR1: begin
        if (accept) begin
          nwords_d = {bus.in_data, cnt_lo_q};
          if ({1'b0, bus.in_data, cnt_lo_q} > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if ({bus.in_data, cnt_lo_q} == 16'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          byte_d = byte_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          case (byte_q)
            2'd0: asm_d[7:0]   = bus.in_data;
            2'd1: asm_d[15:8]  = bus.in_data;
            2'd2: asm_d[23:16] = bus.in_data;
            default: begin
              // Address register is advanced one cycle later, after the pulse.
              mem_we_d    = 1'b1;
              mem_wdata_d = LEN'({bus.in_data, asm_q});
              wdone_d     = wdone_q + 16'd1;
              if (wdone_q + 16'd1 == nwords_q) begin
                state_d = S_FIN;
              end
            end
          endcase
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (bus.in_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_lo_q    <= 8'd0;
      nwords_q    <= 16'd0;
      wdone_q     <= 16'd0;
      byte_q      <= 2'd0;
      asm_q       <= 24'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      nwords_q    <= nwords_d;
      wdone_q     <= wdone_d;
      byte_q      <= byte_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.busy       = in_ready;
  assign bus.done       = (state_q == S_DONE);
  assign bus.error      = (state_q == S_ERROR);
  assign bus.core_reset = (state_q != S_DONE);
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Drives load streams (directed + random) into imem_loader and compares observed writes and status
// against a reference built directly from the stream format; honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  imem_loader_if #(.LEN(32)) bus();

  imem_loader #(.LEN(32), .ADDR_W(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] obs_q[$];
  logic [7:0]  img[0:4095];

  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) obs_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic ls);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk("ready_timeout", 64'(w < 50), 64'(1));
    bus.load_start = ls;
    tick();
    bus.in_valid   = 1'b0;
    bus.load_start = 1'b0;
    bus.in_data    = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   64'(bus.in_ready),   64'(0));
    chk({tag, "_mem_we"},     64'(bus.mem_we),     64'(0));
    chk({tag, "_mem_addr"},   64'(bus.mem_addr),   64'(0));
    chk({tag, "_mem_wdata"},  64'(bus.mem_wdata),  64'(0));
    chk({tag, "_core_reset"}, 64'(bus.core_reset), 64'(1));
    chk({tag, "_busy"},       64'(bus.busy),       64'(0));
    chk({tag, "_done"},       64'(bus.done),       64'(0));
    chk({tag, "_error"},      64'(bus.error),      64'(0));
  endtask

  // One complete load of n words from img[], with 'gap' idle cycles after every byte.
  task automatic do_load(input int n, input int gap, input bit csum_bad, input bit ls_mid);
    logic [7:0]  x;
    logic [15:0] nn;
    bit          exp_err;
    int          exp_w;
    logic [63:0] exp_entry;
    nn = 16'(n);
    obs_q.delete();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    chk("start_core_reset", 64'(bus.core_reset), 64'(1));
    chk("start_busy",       64'(bus.busy),       64'(1));
    chk("start_addr",       64'(bus.mem_addr),   64'(0));
    send(nn[7:0], ls_mid);
    repeat (gap) tick();
    send(nn[15:8], 1'b0);
    exp_err = (n > 1024);
    if (exp_err) chk("hdr_error", 64'(bus.error), 64'(1));
    repeat (gap) tick();
    if (!exp_err) begin
      x = 8'd0;
      for (int i = 0; i < 4 * n; i++) begin
        x ^= img[i];
        send(img[i], ls_mid && i == 1);
        if (i == 4 * n - 1) begin
          chk("last_we",   64'(bus.mem_we),   64'(1));
          chk("last_addr", 64'(bus.mem_addr), 64'(4 * (n - 1)));
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk("last_busy", 64'(bus.busy), 64'(1));
`else
          chk("last_done",       64'(bus.done),       64'(1));
          chk("last_core_reset", 64'(bus.core_reset), 64'(0));
`endif
        end
        repeat (gap) tick();
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(csum_bad ? (x ^ 8'h01) : x, 1'b0);
      exp_err = csum_bad;
`endif
    end
    repeat (3) tick();
    exp_w = (n > 1024) ? 0 : n;
    chk("n_writes", 64'(obs_q.size()), 64'(exp_w));
    for (int k = 0; k < exp_w && k < obs_q.size(); k++) begin
      exp_entry = {32'(4 * k), img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
      chk("write", obs_q[k], exp_entry);
    end
    chk("end_done",       64'(bus.done),       64'(!exp_err));
    chk("end_error",      64'(bus.error),      64'(exp_err));
    chk("end_core_reset", 64'(bus.core_reset), 64'(exp_err));
    chk("end_busy",       64'(bus.busy),       64'(0));
    chk("end_in_ready",   64'(bus.in_ready),   64'(0));
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'd0;
    reset          = 1'b0;
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    tick();
    chk("idle_ignores_valid", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b0;

    // Reference program: addi x0,x0,0 ; addi x1,x0,1
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    img[4] = 8'h93; img[5] = 8'h00; img[6] = 8'h10; img[7] = 8'h00;
    do_load(2, 0, 1'b0, 1'b0);
    do_load(2, 3, 1'b0, 1'b0);

    do_load(16'h0401, 0, 1'b0, 1'b0);
    fill_random(4);
    do_load(1, 0, 1'b0, 1'b0);

    // Asynchronous reset after two bytes of the second word.
    obs_q.delete();
    fill_random(8);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send(img[i], 1'b0);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("mid_writes", 64'(obs_q.size()), 64'(1));
    do_load(1, 1, 1'b0, 1'b0);

    img[0] = 8'h78; img[1] = 8'h56; img[2] = 8'h34; img[3] = 8'h12;
    do_load(1, 0, 1'b0, 1'b0);
    do_load(1, 0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 8));
      fill_random(4 * n);
      do_load(n, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1);
    end

    fill_random(4096);
    do_load(1024, 0, 1'b0, 1'b0);
    do_load(1025, 0, 1'b0, 1'b0);
    do_load(0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
